// File: rtl/game_pkg.sv
// game_pkg: shared screen geometry, coordinate width and kick state encoding.
package game_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int COORD_W  = 10;

    typedef enum logic [1:0] {
        K_IDLE    = 2'd0,
        K_WINDUP  = 2'd1,
        K_ACTIVE  = 2'd2,
        K_RECOVER = 2'd3
    } kick_state_e;

    function automatic int max3(input int a, input int b, input int c);
        return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction

endpackage

// File: rtl/kick_fsm.sv
// kick_fsm: kick press-edge detection, per-phase frame counting and one-hit-per-kick tracking.
// Ports: tick_i frame strobe, btn_kick_i button level, hit_i hit pulse from the owner;
//        state_o current phase, state_d_o phase after this cycle, hit_done_o a hit was
//        already scored in this kick, move_freeze_o movement blocked (WINDUP/ACTIVE).
module kick_fsm
    import game_pkg::*;
#(
    parameter int WINDUP_FRAMES  = 3,
    parameter int ACTIVE_FRAMES  = 6,
    parameter int RECOVER_FRAMES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick_i,
    input  logic        btn_kick_i,
    input  logic        hit_i,
    output kick_state_e state_o,
    output kick_state_e state_d_o,
    output logic        hit_done_o,
    output logic        move_freeze_o
);

    localparam int CNT_W = $clog2(max3(WINDUP_FRAMES, ACTIVE_FRAMES, RECOVER_FRAMES)) + 1;
    localparam logic [CNT_W-1:0] W_LAST = CNT_W'(WINDUP_FRAMES - 1);
    localparam logic [CNT_W-1:0] A_LAST = CNT_W'(ACTIVE_FRAMES - 1);
    localparam logic [CNT_W-1:0] R_LAST = CNT_W'(RECOVER_FRAMES - 1);

    kick_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, last;
    logic             prev_q, hit_done_q, hit_done_d, press;

    always_comb begin
        press      = tick_i && btn_kick_i && !prev_q;
        last       = (state_q == K_WINDUP) ? W_LAST : (state_q == K_ACTIVE) ? A_LAST : R_LAST;
        state_d    = state_q;
        cnt_d      = cnt_q;
        if (tick_i) begin
            if (state_q == K_IDLE) begin
                state_d = press ? K_WINDUP : K_IDLE;
                cnt_d   = '0;
            end else if (cnt_q == last) begin
                // encoding makes WINDUP->ACTIVE->RECOVER->IDLE a plain increment
                state_d = kick_state_e'(state_q + 2'd1);
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        hit_done_d = (state_q == K_IDLE && state_d == K_WINDUP) ? 1'b0 : (hit_done_q | hit_i);
    end

    // previous-kick level resets high so a button held through reset cannot fire
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= K_IDLE;
            cnt_q      <= '0;
            prev_q     <= 1'b1;
            hit_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hit_done_q <= hit_done_d;
            if (tick_i) prev_q <= btn_kick_i;
        end
    end

    assign state_o       = state_q;
    assign state_d_o     = state_d;
    assign hit_done_o    = hit_done_q;
    assign move_freeze_o = (state_q == K_WINDUP) || (state_q == K_ACTIVE);

endmodule

// File: rtl/player_ctrl.sv
// player_ctrl: per-fighter controller; moves the player box and kick hitbox once per frame
// at the start of vertical blanking and scores hits from box pixel overlap.
// Ports: hpos_i/vpos_i beam position, btn_*_i button levels, kick_gfx_i/opp_gfx_i box pixels;
//        px_o/py_o player origin, kx_o/ky_o kick origin, kick_en_o kick armed,
//        facing_left_o facing, kick_state_o kick phase, hit_o one-cycle hit pulse.
// Build option: PLAYER_WRAP_EN makes horizontal movement wrap instead of clamping.
module player_ctrl
    import game_pkg::*;
#(
    parameter int P_W            = 100,
    parameter int P_H            = 100,
    parameter int K_W            = 20,
    parameter int K_H            = 20,
    parameter int SPEED          = 4,
    parameter int START_X        = 100,
    parameter int START_Y        = 100,
    parameter int WINDUP_FRAMES  = 3,
    parameter int ACTIVE_FRAMES  = 6,
    parameter int RECOVER_FRAMES = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COORD_W-1:0] hpos_i,
    input  logic [COORD_W-1:0] vpos_i,
    input  logic               btn_left_i,
    input  logic               btn_right_i,
    input  logic               btn_up_i,
    input  logic               btn_down_i,
    input  logic               btn_kick_i,
    input  logic               kick_gfx_i,
    input  logic               opp_gfx_i,
    output logic [COORD_W-1:0] px_o,
    output logic [COORD_W-1:0] py_o,
    output logic [COORD_W-1:0] kx_o,
    output logic [COORD_W-1:0] ky_o,
    output logic               kick_en_o,
    output logic               facing_left_o,
    output logic [1:0]         kick_state_o,
    output logic               hit_o
);

    localparam logic signed [10:0]  SPD     = 11'(SPEED);
    localparam logic signed [10:0]  X_MAX_S = 11'(SCREEN_W - P_W);
    localparam logic signed [10:0]  Y_MAX_S = 11'(SCREEN_H - P_H);
    localparam logic [COORD_W-1:0]  X_MAX   = COORD_W'(SCREEN_W - P_W);
    localparam logic [COORD_W-1:0]  Y_MAX   = COORD_W'(SCREEN_H - P_H);
    localparam logic [COORD_W-1:0]  K_OFF_Y = COORD_W'((P_H - K_H) / 2);

    kick_state_e        st_q, st_d;
    logic               frz, hit_done;
    logic               tick, hmove, vmove, legal;
    logic signed [10:0] sx, sy, nx, ny;
    logic [10:0]        pxw;
    logic [COORD_W-1:0] px_q, px_d, py_q, py_d, kx_q, kx_d, ky_q, ky_d, nx_lim;
    logic               kick_en_q, kick_en_d, facing_q, facing_d;
    logic               seen_q, seen_d, hit_q, hit_d;

    kick_fsm #(
        .WINDUP_FRAMES (WINDUP_FRAMES),
        .ACTIVE_FRAMES (ACTIVE_FRAMES),
        .RECOVER_FRAMES(RECOVER_FRAMES)
    ) u_kick_fsm (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick_i       (tick),
        .btn_kick_i   (btn_kick_i),
        .hit_i        (hit_q),
        .state_o      (st_q),
        .state_d_o    (st_d),
        .hit_done_o   (hit_done),
        .move_freeze_o(frz)
    );

    always_comb begin
        tick   = (hpos_i == '0) && (vpos_i == COORD_W'(SCREEN_H));
        hmove  = btn_left_i ^ btn_right_i;
        vmove  = btn_up_i ^ btn_down_i;
        sx     = (!hmove || frz) ? '0 : (btn_left_i ? -SPD : SPD);
        sy     = (!vmove || frz) ? '0 : (btn_up_i ? -SPD : SPD);
        nx     = $signed({1'b0, px_q}) + sx;
        ny     = $signed({1'b0, py_q}) + sy;
`ifdef PLAYER_WRAP_EN
        nx_lim = nx[10] ? X_MAX : (nx > X_MAX_S) ? '0 : nx[COORD_W-1:0];
`else
        nx_lim = nx[10] ? '0 : (nx > X_MAX_S) ? X_MAX : nx[COORD_W-1:0];
`endif
        px_d      = tick ? nx_lim : px_q;
        py_d      = tick ? (ny[10] ? '0 : (ny > Y_MAX_S) ? Y_MAX : ny[COORD_W-1:0]) : py_q;
        facing_d  = (tick && hmove) ? btn_left_i : facing_q;
        // geometry follows the post-tick position so it lands in the same edge as px/py
        pxw       = {1'b0, px_d};
        legal     = facing_d ? (pxw >= 11'(K_W)) : (pxw + 11'(P_W + K_W) <= 11'(SCREEN_W));
        kx_d      = !legal ? px_d : facing_d ? px_d - COORD_W'(K_W) : px_d + COORD_W'(P_W);
        ky_d      = py_d + K_OFF_Y;
        kick_en_d = (st_d == K_ACTIVE) && legal;
        seen_d    = !tick && (seen_q || (kick_gfx_i && opp_gfx_i && kick_en_q));
        hit_d     = tick && seen_q && (st_q == K_ACTIVE) && !hit_done;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px_q      <= COORD_W'(START_X);
            py_q      <= COORD_W'(START_Y);
            kx_q      <= COORD_W'(START_X + P_W);
            ky_q      <= COORD_W'(START_Y + (P_H - K_H) / 2);
            kick_en_q <= 1'b0;
            facing_q  <= 1'b0;
            seen_q    <= 1'b0;
            hit_q     <= 1'b0;
        end else begin
            px_q      <= px_d;
            py_q      <= py_d;
            kx_q      <= kx_d;
            ky_q      <= ky_d;
            kick_en_q <= kick_en_d;
            facing_q  <= facing_d;
            seen_q    <= seen_d;
            hit_q     <= hit_d;
        end
    end

    assign px_o          = px_q;
    assign py_o          = py_q;
    assign kx_o          = kx_q;
    assign ky_o          = ky_q;
    assign kick_en_o     = kick_en_q;
    assign facing_left_o = facing_q;
    assign kick_state_o  = st_q;
    assign hit_o         = hit_q;

endmodule
